// File: rtl/pong_pkg.sv
// pong_pkg: shared types and timing defaults for the joystick front end and
// its paddle consumers.
//   deb_state_e     - per-switch debounce state
//   DEBOUNCE_CYCLES - stable cycles needed to accept a level change (5 ms @ 50 MHz)
//   REPEAT_DELAY    - cycles held before the first auto-repeat pulse (0.5 s)
//   REPEAT_PERIOD   - cycles between later auto-repeat pulses (0.1 s)
//   CONTROL_ACTIVE  - level of control_up/control_down that means "move"
package pong_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } deb_state_e;

   localparam int   DEBOUNCE_CYCLES = 250000;
   localparam int   REPEAT_DELAY    = 25000000;
   localparam int   REPEAT_PERIOD   = 5000000;

   localparam logic CONTROL_ACTIVE  = 1'b0;

endpackage

// File: rtl/joystick_conditioner_debounce_channel.sv
// debounce_channel: synchroniser, debounce FSM and auto-repeat timer for one
// active-low mechanical switch.
//   clock    - system clock
//   reset    - synchronous, active-high
//   btn_n_i  - raw switch, asynchronous, 0 = pressed
//   held_o   - debounced level, 1 while PRESSED or RELEASE_WAIT
//   press_o  - one-cycle pulse on acceptance and on each auto-repeat
module debounce_channel #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 25,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_n_i,
   output logic held_o,
   output logic press_o
);
   import pong_pkg::*;

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_FIRST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RPT_NEXT   = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic             RPT_EN     = (REPEAT_DELAY != 0);

   logic [SYNC_STAGES-1:0] sync_q;
   deb_state_e             state_q, state_d;
   // One counter serves both roles: debounce count in the WAIT states and
   // repeat timer in PRESSED. Every state change clears it.
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   // Set once the first repeat pulse has fired; later pulses use the period.
   logic                   rpt_armed_q, rpt_armed_d;
   logic                   press_q, press_d;
   logic                   pressed_s;
   logic [CNT_W-1:0]       rpt_limit_s;

   assign pressed_s   = ~sync_q[SYNC_STAGES-1];
   assign rpt_limit_s = rpt_armed_q ? RPT_NEXT : RPT_FIRST;

   // Synchroniser chain; resets to the released level.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
      end
   end

   // State, counter and pulse registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= RELEASED;
         cnt_q       <= '0;
         rpt_armed_q <= 1'b0;
         press_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rpt_armed_q <= rpt_armed_d;
         press_q     <= press_d;
      end
   end

   // Next-state, counter and pulse decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rpt_armed_d = rpt_armed_q;
      press_d     = 1'b0;
      case (state_q)
         RELEASED: begin
            cnt_d = '0;
            if (pressed_s) begin
               state_d = PRESS_WAIT;
            end else begin
               state_d = RELEASED;
            end
         end
         PRESS_WAIT: begin
            if (!pressed_s) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d     = PRESSED;
               cnt_d       = '0;
               rpt_armed_d = 1'b0;
               press_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!pressed_s) begin
               state_d     = RELEASE_WAIT;
               cnt_d       = '0;
               rpt_armed_d = 1'b0;
            end else if (RPT_EN) begin
               if (cnt_q == rpt_limit_s) begin
                  cnt_d       = '0;
                  rpt_armed_d = 1'b1;
                  press_d     = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               cnt_d = '0;
            end
         end
         RELEASE_WAIT: begin
            if (pressed_s) begin
               // Bounce on release: back to PRESSED with a fresh repeat delay.
               state_d     = PRESSED;
               cnt_d       = '0;
               rpt_armed_d = 1'b0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d     = RELEASED;
            cnt_d       = '0;
            rpt_armed_d = 1'b0;
         end
      endcase
   end

   assign held_o  = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
   assign press_o = press_q;

endmodule

// File: rtl/joystick_conditioner.sv
// joystick_conditioner: debounces the up/down joystick switches and drives
// conflict-free active-low level commands plus menu press pulses.
//   clock        - system clock
//   reset        - synchronous, active-high
//   btn_up_n     - raw up switch, asynchronous, 0 = pressed
//   btn_down_n   - raw down switch, asynchronous, 0 = pressed
//   control_up   - debounced up level, 0 = move up
//   control_down - debounced down level, 0 = move down
//   press_up     - one-cycle pulse on up acceptance and each repeat
//   press_down   - one-cycle pulse on down acceptance and each repeat
module joystick_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = pong_pkg::DEBOUNCE_CYCLES,
   // Wide enough for the largest 50 MHz default (REPEAT_DELAY).
   parameter int CNT_W           = 25,
   parameter int REPEAT_DELAY    = pong_pkg::REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = pong_pkg::REPEAT_PERIOD
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_up_n,
   input  logic btn_down_n,
   output logic control_up,
   output logic control_down,
   output logic press_up,
   output logic press_down
);
   import pong_pkg::*;

   logic held_up_s, held_dn_s;
   logic press_up_s, press_dn_s;

   debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
   ) u_up (
      .clock  (clock),
      .reset  (reset),
      .btn_n_i(btn_up_n),
      .held_o (held_up_s),
      .press_o(press_up_s)
   );

   debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
   ) u_dn (
      .clock  (clock),
      .reset  (reset),
      .btn_n_i(btn_down_n),
      .held_o (held_dn_s),
      .press_o(press_dn_s)
   );

   // Both held cancels out: neither direction is driven and no pulse escapes.
   // All terms come straight from channel registers, never from the pins.
   assign control_up   = (held_up_s & ~held_dn_s) ? CONTROL_ACTIVE : ~CONTROL_ACTIVE;
   assign control_down = (held_dn_s & ~held_up_s) ? CONTROL_ACTIVE : ~CONTROL_ACTIVE;
   assign press_up     = press_up_s & ~held_dn_s;
   assign press_down   = press_dn_s & ~held_up_s;

endmodule

// File: tb/tb_joystick_conditioner.sv
module tb_joystick_conditioner;

   localparam int S  = 2;
   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;
   localparam int W  = 4;

   logic clock = 1'b0;
   logic reset, btn_up_n, btn_down_n;
   logic control_up, control_down, press_up, press_down;
   logic nr_cu, nr_cd, nr_pu, nr_pd;
   logic [7:0] act_vec;
   logic [7:0] exp_vec = 8'hCC;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   joystick_conditioner #(
      .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(W),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clock(clock), .reset(reset), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
      .control_up(control_up), .control_down(control_down),
      .press_up(press_up), .press_down(press_down)
   );

   joystick_conditioner #(
      .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(W),
      .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)
   ) dut_nr (
      .clock(clock), .reset(reset), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
      .control_up(nr_cu), .control_down(nr_cd),
      .press_up(nr_pu), .press_down(nr_pd)
   );

   assign act_vec = {control_up, control_down, press_up, press_down,
                     nr_cu, nr_cd, nr_pu, nr_pd};

   // Reference model: a sampled pin is the value S edges old; the debounced
   // level flips once the sample has disagreed with it for D+1 consecutive
   // edges. k counts edges of uninterrupted acceptance since the press (or
   // since a release bounce ended); repeats fire at k = RD, RD+RP, ...
   bit pipe [2][S];
   bit lvl  [2];
   int run  [2];
   int k    [2];
   bit pulse[2][2];

   always @(posedge clock) begin
      bit pins [2];
      bit s_pr;
      pins[0] = btn_up_n;
      pins[1] = btn_down_n;
      for (int ch = 0; ch < 2; ch++) begin
         pulse[0][ch] = 1'b0;
         pulse[1][ch] = 1'b0;
         if (reset) begin
            for (int i = 0; i < S; i++) pipe[ch][i] = 1'b1;
            lvl[ch] = 1'b0;
            run[ch] = 0;
            k[ch]   = 0;
         end else begin
            s_pr = ~pipe[ch][S-1];
            for (int i = S-1; i > 0; i--) pipe[ch][i] = pipe[ch][i-1];
            pipe[ch][0] = pins[ch];
            if (s_pr != lvl[ch]) begin
               run[ch]++;
               if (run[ch] == D + 1) begin
                  lvl[ch] = s_pr;
                  run[ch] = 0;
                  k[ch]   = 0;
                  if (s_pr) begin
                     pulse[0][ch] = 1'b1;
                     pulse[1][ch] = 1'b1;
                  end
               end
            end else begin
               if (lvl[ch] && run[ch] != 0) begin
                  k[ch] = 0;
               end else if (lvl[ch]) begin
                  k[ch]++;
                  if (k[ch] >= RD && (k[ch] - RD) % RP == 0) pulse[0][ch] = 1'b1;
               end
               run[ch] = 0;
            end
         end
      end
      for (int c = 0; c < 2; c++) begin
         exp_vec[7-4*c] = ~(lvl[0] & ~lvl[1]);
         exp_vec[6-4*c] = ~(lvl[1] & ~lvl[0]);
         exp_vec[5-4*c] = pulse[c][0] & ~lvl[1];
         exp_vec[4-4*c] = pulse[c][1] & ~lvl[0];
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset();
      int got = 0;
      reset = 1'b1; btn_up_n = 1'b0; btn_down_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++;
         if (act_vec !== 8'hCC) begin
            errors++;
            $display("FAIL reset_values cycle=%0d got=%b exp=%b", i, act_vec, 8'hCC);
         end
      end
      btn_down_n = 1'b1;
      reset = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL reset_model n=%0d got=%b exp=%b", n, act_vec, exp_vec);
         end
         if (got == 0 && control_up === 1'b0) got = n;
      end
      checks++;
      if (got !== 7) begin
         errors++;
         $display("FAIL reset_release_latency got=%0d exp=7", got);
      end
      btn_up_n = 1'b1;
      idle(12);
   endtask

   task automatic test_bounce();
      bit pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      int got_c = 0, got_p = 0, npulse = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL bounce_model i=%0d got=%b exp=%b", i, act_vec, exp_vec);
         end
         btn_up_n = pat[i];
      end
      @(negedge clock);
      checks++;
      if (control_up !== 1'b1) begin
         errors++;
         $display("FAIL bounce_reject got=%b exp=1", control_up);
      end
      btn_up_n = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clock);
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL bounce_model n=%0d got=%b exp=%b", n, act_vec, exp_vec);
         end
         if (got_c == 0 && control_up === 1'b0) got_c = n;
         if (press_up === 1'b1) begin
            npulse++;
            if (got_p == 0) got_p = n;
         end
      end
      checks++;
      if (got_c !== 7 || got_p !== 7 || npulse !== 1) begin
         errors++;
         $display("FAIL bounce_accept level_at=%0d pulse_at=%0d pulses=%0d exp 7 7 1",
                  got_c, got_p, npulse);
      end
      btn_up_n = 1'b1;
      idle(12);
   endtask

   task automatic test_repeat();
      int q[$];
      int exp_rel [5] = '{0, 10, 13, 16, 19};
      int got = 0;
      btn_up_n = 1'b0;
      for (int n = 1; n <= 27; n++) begin
         @(negedge clock);
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL repeat_model n=%0d got=%b exp=%b", n, act_vec, exp_vec);
         end
         if (press_up === 1'b1) q.push_back(n - 7);
      end
      checks++;
      if (q.size() !== 5) begin
         errors++;
         $display("FAIL repeat_count got=%0d exp=5", q.size());
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= q.size() || q[i] !== exp_rel[i]) begin
            errors++;
            $display("FAIL repeat_time idx=%0d got=%0d exp=%0d", i,
                     (i < q.size()) ? q[i] : -1, exp_rel[i]);
         end
      end
      btn_up_n = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clock);
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL release_model n=%0d got=%b exp=%b", n, act_vec, exp_vec);
         end
         if (got == 0 && control_up === 1'b1) got = n;
      end
      checks++;
      if (got !== 7) begin
         errors++;
         $display("FAIL release_latency got=%0d exp=7", got);
      end
      idle(4);
   endtask

   task automatic test_conflict();
      int got_u = 0, got_d = 0, npd = 0;
      btn_up_n = 1'b0;
      idle(10);
      btn_down_n = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clock);
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL conflict_model n=%0d got=%b exp=%b", n, act_vec, exp_vec);
         end
         if (got_u == 0 && control_up === 1'b1) got_u = n;
         if (press_down === 1'b1) npd++;
      end
      checks++;
      if (got_u !== 7 || control_down !== 1'b1 || npd !== 0) begin
         errors++;
         $display("FAIL conflict_cancel up_off_at=%0d down=%b press_down=%0d exp 7 1 0",
                  got_u, control_down, npd);
      end
      btn_up_n = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clock);
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL handover_model n=%0d got=%b exp=%b", n, act_vec, exp_vec);
         end
         if (got_d == 0 && control_down === 1'b0) got_d = n;
      end
      checks++;
      if (got_d !== 7) begin
         errors++;
         $display("FAIL handover_latency got=%0d exp=7", got_d);
      end
      btn_down_n = 1'b1;
      idle(12);
   endtask

   task automatic test_reset_abort();
      int got = 0, np = 0;
      btn_up_n = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clock);
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL abort_model n=%0d got=%b exp=%b", n, act_vec, exp_vec);
         end
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (act_vec !== 8'hCC) begin
         errors++;
         $display("FAIL abort_reset_values got=%b exp=%b", act_vec, 8'hCC);
      end
      reset = 1'b0;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clock);
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL abort_model post n=%0d got=%b exp=%b", n, act_vec, exp_vec);
         end
         if (got == 0 && control_up === 1'b0) got = n;
         if (press_up === 1'b1) np++;
      end
      checks++;
      if (got !== 7 || np !== 1) begin
         errors++;
         $display("FAIL abort_reaccept level_at=%0d pulses=%0d exp 7 1", got, np);
      end
      btn_up_n = 1'b1;
      idle(12);
   endtask

   task automatic test_no_repeat();
      int n_nr = 0, n_main = 0;
      btn_up_n = 1'b0;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clock);
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL norepeat_model n=%0d got=%b exp=%b", n, act_vec, exp_vec);
         end
         if (nr_pu === 1'b1) n_nr++;
         if (press_up === 1'b1) n_main++;
      end
      checks++;
      if (n_nr !== 1 || n_main !== 13) begin
         errors++;
         $display("FAIL norepeat_count nr=%0d main=%0d exp 1 13", n_nr, n_main);
      end
      btn_up_n = 1'b1;
      idle(12);
   endtask

   task automatic test_random();
      int len;
      bit up, dn, rst;
      for (int seg = 0; seg < 80; seg++) begin
         len = $urandom_range(1, 30);
         up  = ($urandom & 1) != 0;
         dn  = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 19) == 0);
         for (int i = 0; i < len; i++) begin
            @(negedge clock);
            checks++;
            if (act_vec !== exp_vec) begin
               errors++;
               $display("FAIL random_model seg=%0d i=%0d got=%b exp=%b",
                        seg, i, act_vec, exp_vec);
            end
            btn_up_n   = up;
            btn_down_n = dn;
            reset      = (i == 0) ? rst : 1'b0;
         end
      end
      reset = 1'b0; btn_up_n = 1'b1; btn_down_n = 1'b1;
      idle(12);
   endtask

   initial begin
      reset = 1'b1; btn_up_n = 1'b1; btn_down_n = 1'b1;
      test_reset();
      test_bounce();
      test_repeat();
      test_conflict();
      test_reset_abort();
      test_no_repeat();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
